dct_block_sequencer: RTL and testbench

// - Control-only sequencer for the 8x8 2-D DCT of the JPEG compressor. Runs a shared 1-D DCT

---
 rtl/dct_block_sequencer_pkg.sv | 28 ++
 rtl/dct_block_sequencer.sv | 129 ++++++++++++
 tb/tb_dct_block_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dct_block_sequencer_pkg.sv
// Shared geometry and state encoding for the 8x8 DCT block sequencer.
// Datapath testbenches reuse these names.
package dct_block_sequencer_pkg;

  localparam int BLK_N  = 8;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 6;

  typedef enum logic [3:0] {
    S_LOAD   = 4'd0,
    S_RSTART = 4'd1,
    S_RWAIT  = 4'd2,
    S_RWRITE = 4'd3,
    S_CREAD  = 4'd4,
    S_CFLUSH = 4'd5,
    S_CSTART = 4'd6,
    S_CWAIT  = 4'd7,
    S_COUT   = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  // Row-major 8x8 address from (major, minor) index pair.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [IDX_W-1:0] major,
                                                 input logic [IDX_W-1:0] minor);
    return {major, minor};
  endfunction

endpackage

// File: rtl/dct_block_sequencer.sv
// Control sequencer for a 2-D 8x8 DCT: row pass into a transpose buffer, then column pass to output.
// Carries no sample data; drives datapath strobes, buffer addresses and coefficient indexing.
module dct_block_sequencer
  import dct_block_sequencer_pkg::*;
#(
  parameter int DP_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dp_load,
  output logic [IDX_W-1:0]  dp_load_idx,
  output logic              dp_start,
  output logic              dp_mode,
  output logic [IDX_W-1:0]  dp_rd_idx,
  output logic              tb_we,
  output logic [ADDR_W-1:0] tb_waddr,
  output logic              tb_re,
  output logic [ADDR_W-1:0] tb_raddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic              block_done,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST     = IDX_W'(BLK_N - 1);
  localparam logic [3:0]       LAT_LAST = 4'(DP_LAT - 1);

  state_t           state;
  logic [IDX_W-1:0] r, c, k;
  logic [3:0]       lat;
  logic             ld_d;
  logic [IDX_W-1:0] k_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      r     <= '0;
      c     <= '0;
      k     <= '0;
      lat   <= '0;
      ld_d  <= 1'b0;
      k_d   <= '0;
    end else begin
      // Buffer read data arrives one cycle after tb_re, so the load strobe trails it.
      ld_d <= (state == S_CREAD);
      k_d  <= k;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            k <= k + 3'd1;
            if (k == LAST) state <= S_RSTART;
          end
        end
        S_RSTART: state <= S_RWAIT;
        S_RWAIT: begin
          if (lat == LAT_LAST) begin
            lat   <= '0;
            state <= S_RWRITE;
          end else begin
            lat <= lat + 4'd1;
          end
        end
        S_RWRITE: begin
          k <= k + 3'd1;
          if (k == LAST) begin
            if (r == LAST) begin
              r     <= '0;
              c     <= '0;
              state <= S_CREAD;
            end else begin
              r     <= r + 3'd1;
              state <= S_LOAD;
            end
          end
        end
        S_CREAD: begin
          k <= k + 3'd1;
          if (k == LAST) state <= S_CFLUSH;
        end
        S_CFLUSH: state <= S_CSTART;
        S_CSTART: state <= S_CWAIT;
        S_CWAIT: begin
          if (lat == LAT_LAST) begin
            lat   <= '0;
            state <= S_COUT;
          end else begin
            lat <= lat + 4'd1;
          end
        end
        S_COUT: begin
          if (out_ready) begin
            k <= k + 3'd1;
            if (k == LAST) begin
              if (c == LAST) begin
                c     <= '0;
                state <= S_DONE;
              end else begin
                c     <= c + 3'd1;
                state <= S_CREAD;
              end
            end
          end
        end
        S_DONE:  state <= S_LOAD;
        default: state <= S_LOAD;
      endcase
    end
  end

  assign in_ready    = (state == S_LOAD);
  assign dp_load     = (in_ready && in_valid) || ld_d;
  assign dp_load_idx = ld_d ? k_d : k;
  assign dp_start    = (state == S_RSTART) || (state == S_CSTART);
  assign dp_mode     = (state == S_CREAD) || (state == S_CFLUSH) || (state == S_CSTART) ||
                       (state == S_CWAIT) || (state == S_COUT);
  assign dp_rd_idx   = k;
  assign tb_we       = (state == S_RWRITE);
  assign tb_waddr    = blk_addr(k, r);
  assign tb_re       = (state == S_CREAD);
  assign tb_raddr    = blk_addr(c, k);
  assign out_valid   = (state == S_COUT);
  assign out_idx     = blk_addr(k, c);
  assign block_done  = (state == S_DONE);
  assign busy        = !((state == S_LOAD) && (r == '0) && (k == '0));

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Scoreboard bench for dct_block_sequencer: expected strobes/addresses queued per block,
// a negedge monitor pops and compares whenever the DUT asserts the matching output.
module tb_dct_block_sequencer;

  localparam int DP_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       dp_load;
  logic [2:0] dp_load_idx;
  logic       dp_start;
  logic       dp_mode;
  logic [2:0] dp_rd_idx;
  logic       tb_we;
  logic [5:0] tb_waddr;
  logic       tb_re;
  logic [5:0] tb_raddr;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_idx;
  logic       block_done;
  logic       busy;

  dct_block_sequencer #(.DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dp_load(dp_load), .dp_load_idx(dp_load_idx), .dp_start(dp_start), .dp_mode(dp_mode),
    .dp_rd_idx(dp_rd_idx), .tb_we(tb_we), .tb_waddr(tb_waddr), .tb_re(tb_re),
    .tb_raddr(tb_raddr), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .block_done(block_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int q_load[$];   // mode*8 + slot
  int q_start[$];  // mode
  int q_waddr[$];
  int q_raddr[$];
  int q_out[$];

  int done_cnt = 0, done_cyc = 0, first_acc_cyc = 0, col_starts = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_block();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        q_load.push_back(k);
        q_waddr.push_back(k * 8 + r);
      end
      q_start.push_back(0);
    end
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) begin
        q_raddr.push_back(c * 8 + k);
        q_load.push_back(8 + k);
        q_out.push_back(k * 8 + c);
      end
      q_start.push_back(1);
    end
  endtask

  task automatic clear_queues();
    q_load.delete(); q_start.delete(); q_waddr.delete(); q_raddr.delete(); q_out.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("reset_outputs_zero",
        int'({dp_load, dp_start, dp_mode, tb_we, tb_re, out_valid, block_done, busy,
              dp_load_idx, dp_rd_idx, tb_waddr, tb_raddr, out_idx}), 0);
  endtask

  // Monitor / scoreboard
  initial begin
    int blk_acc = 0, last_acc_cyc = 0, last_re_cyc = 0, last_start_cyc = 0, we_cnt = 0;
    bit prev_re = 0, prev_stall = 0;
    int prev_raddr = 0, prev_idx = 0, prev_rd = 0;
    int e;
    forever begin
      @(negedge clk);
      if (rst) begin
        blk_acc = 0; we_cnt = 0; col_starts = 0;
        prev_re = 0; prev_stall = 0;
        continue;
      end
      chk("excl_we_re", int'(tb_we & tb_re), 0);
      chk("excl_start_load", int'(dp_start & dp_load), 0);
      if (in_valid && in_ready) begin
        if (blk_acc == 0) first_acc_cyc = cyc;
        blk_acc++;
        last_acc_cyc = cyc;
      end
      if (dp_load) begin
        if (q_load.size() == 0) chk("load_unexpected", 1, 0);
        else begin
          e = q_load.pop_front();
          chk("load_mode", int'(dp_mode), e / 8);
          chk("load_idx", int'(dp_load_idx), e % 8);
        end
        if (!dp_mode) chk("load_only_on_accept", int'(in_valid & in_ready), 1);
        else begin
          chk("load_lags_re", int'(prev_re), 1);
          chk("load_idx_vs_raddr", int'(dp_load_idx), prev_raddr % 8);
        end
      end
      if (dp_start) begin
        if (q_start.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          e = q_start.pop_front();
          chk("start_mode", int'(dp_mode), e);
          if (e == 0) chk("row_start_after_accept", cyc - last_acc_cyc, 1);
          else begin
            chk("col_start_after_re", cyc - last_re_cyc, 2);
            col_starts++;
          end
        end
        last_start_cyc = cyc;
      end
      if (tb_we) begin
        if (q_waddr.size() == 0) chk("waddr_unexpected", 1, 0);
        else begin
          e = q_waddr.pop_front();
          chk("tb_waddr", int'(tb_waddr), e);
          chk("we_rd_idx", int'(dp_rd_idx), e / 8);
        end
        if (we_cnt % 8 == 0) chk("row_write_latency", cyc - last_start_cyc, DP_LAT + 1);
        we_cnt++;
      end
      if (tb_re) begin
        if (q_raddr.size() == 0) chk("raddr_unexpected", 1, 0);
        else begin
          e = q_raddr.pop_front();
          chk("tb_raddr", int'(tb_raddr), e);
        end
        last_re_cyc = cyc;
      end
      if (out_valid) begin
        if (prev_stall) begin
          chk("stall_hold_out_idx", int'(out_idx), prev_idx);
          chk("stall_hold_rd_idx", int'(dp_rd_idx), prev_rd);
        end
        if (out_ready) begin
          if (q_out.size() == 0) chk("out_unexpected", 1, 0);
          else begin
            e = q_out.pop_front();
            chk("out_idx", int'(out_idx), e);
            chk("out_rd_idx", int'(dp_rd_idx), e / 8);
          end
        end
      end
      if (block_done) begin
        done_cnt++;
        done_cyc = cyc;
        blk_acc = 0; we_cnt = 0; col_starts = 0;
      end
      prev_re    = tb_re;
      prev_raddr = int'(tb_raddr);
      prev_stall = out_valid && !out_ready;
      prev_idx   = int'(out_idx);
      prev_rd    = int'(dp_rd_idx);
    end
  end

  // gap: idle cycles between offered samples; stall: out_ready follows 1-0-0-1;
  // abort_col >= 0: assert rst in CWAIT of that column instead of finishing.
  task automatic run_block(input int gap, input bit stall, input int abort_col, input bit chk_time);
    int acc = 0, phase = 0, n = 0, d0;
    bit want;
    logic [3:0] orpat = 4'b1001;
    d0 = done_cnt;
    push_block();
    while (done_cnt == d0) begin
      if (abort_col >= 0 && col_starts == abort_col + 1) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        clear_queues();
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs();
        return;
      end
      if (n == 4000) begin
        chk("block_timeout", done_cnt, d0 + 1);
        in_valid = 1'b0;
        return;
      end
      want = (acc < 64) && (phase == 0);
      phase = (gap == 0) ? 0 : (phase + 1) % (gap + 1);
      in_valid = want;
      if (want && in_ready) acc++;
      out_ready = stall ? orpat[cyc % 4] : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("busy_after_done", int'(busy), 0);
    chk("in_ready_after_done", int'(in_ready), 1);
    chk("load_queue_drained", q_load.size(), 0);
    chk("start_queue_drained", q_start.size(), 0);
    chk("waddr_queue_drained", q_waddr.size(), 0);
    chk("raddr_queue_drained", q_raddr.size(), 0);
    chk("out_queue_drained", q_out.size(), 0);
    if (chk_time) chk("block_cycles", done_cyc - first_acc_cyc + 1, 345);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs();
    run_block(0, 1'b0, -1, 1'b1);
    run_block(3, 1'b1, -1, 1'b0);
    run_block(0, 1'b0, 5, 1'b0);
    run_block(0, 1'b0, -1, 1'b1);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
